// File: rtl/serial_adder.sv
// serial_adder: multi-cycle adder/subtractor that processes SLICE bits per
// clock, least-significant slice first, over N = WIDTH/SLICE RUN cycles.
//
// Ports:
//   clk   - clock, all state updates on the rising edge
//   rst   - synchronous active-high reset
//   start - request; a, b, cin and sub are sampled when it is accepted
//           (IDLE or DONE only, never while rst is high)
//   a, b  - WIDTH-bit operands
//   cin   - carry-in for addition (ignored when sub=1)
//   sub   - 0: a+b+cin, 1: a-b (a+~b+1)
//   busy  - high while an operation is in RUN
//   done  - one-cycle pulse when sum/cout/ovf/zero are freshly loaded
//   sum   - registered WIDTH-bit result, held until the next result load
//   cout  - carry out of the MSB (for subtraction, 1 means no borrow)
//   ovf   - signed overflow (carry into MSB xor carry out of MSB)
//   zero  - high when sum == 0
module serial_adder #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned SLICE = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic             zero
);

  localparam int unsigned N     = WIDTH / SLICE;
  localparam int unsigned CNT_W = (N > 1) ? $clog2(N) : 1;
  localparam int unsigned SW    = SLICE + 1;

  // Elaboration-time guard on the slicing parameters.
  if (SLICE == 0 || SLICE > WIDTH || (WIDTH % SLICE) != 0) begin : g_bad_params
    $error("serial_adder: WIDTH must be a nonzero integer multiple of SLICE");
  end

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   a_q, a_d;
  logic [WIDTH-1:0]   b_q, b_d;       // already inverted for subtraction
  logic [WIDTH-1:0]   acc_q, acc_d;
  logic               carry_q, carry_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic [WIDTH-1:0]   sum_q, sum_d;
  logic               cout_q, cout_d;
  logic               ovf_q, ovf_d;
  logic               zero_q, zero_d;

  logic               accept_c;
  logic               last_c;
  int unsigned        lsb_c;
  logic [SLICE-1:0]   sa_c;
  logic [SLICE-1:0]   sb_c;
  logic [SW-1:0]      ssum_c;
  logic               msb_cin_c;

  // Slice datapath: select the current slice by shifting, add with running carry.
  always_comb begin
    lsb_c     = 32'(cnt_q) * SLICE;
    sa_c      = SLICE'(a_q >> lsb_c);
    sb_c      = SLICE'(b_q >> lsb_c);
    ssum_c    = SW'(sa_c) + SW'(sb_c) + SW'(carry_q);
    // Sum bit = a ^ b ^ carry_in, so the carry into the top bit falls out directly.
    msb_cin_c = ssum_c[SLICE-1] ^ sa_c[SLICE-1] ^ sb_c[SLICE-1];
    last_c    = (cnt_q == CNT_W'(N - 1));
    accept_c  = start && ((state_q == IDLE) || (state_q == DONE));
  end

  // Next-state and next-output logic.
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    acc_d   = acc_q;
    carry_d = carry_q;
    cnt_d   = cnt_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    zero_d  = zero_q;

    case (state_q)
      IDLE, DONE: begin
        if (accept_c) begin
          a_d     = a;
          b_d     = sub ? ~b : b;
          carry_d = sub ? 1'b1 : cin;
          cnt_d   = '0;
          acc_d   = '0;
          state_d = RUN;
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        acc_d   = acc_q | (WIDTH'(ssum_c[SLICE-1:0]) << lsb_c);
        carry_d = ssum_c[SLICE];
        cnt_d   = cnt_q + CNT_W'(1);
        if (last_c) begin
          sum_d   = acc_d;
          cout_d  = ssum_c[SLICE];
          ovf_d   = msb_cin_c ^ ssum_c[SLICE];
          zero_d  = (acc_d == '0);
          state_d = DONE;
        end
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d == RUN);
    done_d = (state_d == DONE);
  end

  // All state, with synchronous reset taking priority over any request.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      acc_q   <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
      zero_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      acc_q   <= acc_d;
      carry_q <= carry_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
      zero_q  <= zero_d;
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign sum  = sum_q;
  assign cout = cout_q;
  assign ovf  = ovf_q;
  assign zero = zero_q;

endmodule
